// File: rtl/prog_clock_divider.sv
// ---------------------------------------------------------------------------
// prog_clock_divider
//   Programmable clock divider with square, pulse and legacy power-of-two
//   modes. A new configuration is held in a shadow register and only
//   becomes active at a period boundary, so the output never glitches
//   mid-period.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   en           run enable, low holds the divider idle
//   cfg_div      requested divide value D (period P = D+1 clk cycles)
//   cfg_mode     00 square, 01 pulse, 10 legacy 2^(sel+1), 11 as square
//   cfg_load     one-cycle strobe capturing cfg_div/cfg_mode
//   clk_out      registered divided clock / pulse
//   tick         registered strobe on the first cycle of each new period
//   cfg_pending  a loaded configuration waits for the next period boundary
//   dbg_state    FSM state (0 idle, 1 run)
//   dbg_cnt      period counter
//
// Handshake: cfg_load is a plain strobe with no ready; it is accepted on
//   every edge where rst_n is high. Loads are never refused: a later load
//   overwrites an earlier one that has not been applied yet.
// ---------------------------------------------------------------------------
module prog_clock_divider #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [1:0]       cfg_mode,
  input  logic             cfg_load,
  output logic             clk_out,
  output logic             tick,
  output logic             cfg_pending,
  output logic             dbg_state,
  output logic [CNT_W-1:0] dbg_cnt
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [4:0] SEL_MAX = 5'(CNT_W - 1);

  // Legacy mode bit select, clamped to the counter width.
  function automatic logic [4:0] f_sel(input logic [CNT_W-1:0] div);
    return (div[4:0] > SEL_MAX) ? SEL_MAX : div[4:0];
  endfunction

  // Effective divide value: zero is treated as one.
  function automatic logic [CNT_W-1:0] f_deff(input logic [CNT_W-1:0] div);
    return (div == '0) ? CNT_W'(1) : div;
  endfunction

  // Last counter value of a period (P-1). P itself needs CNT_W+1 bits,
  // P-1 always fits in CNT_W bits.
  function automatic logic [CNT_W-1:0] f_last(input logic [CNT_W-1:0] div,
                                              input logic [1:0]       mode);
    logic [CNT_W:0] p;
    if (mode == 2'b10)
      p = (CNT_W+1)'(1) << ({1'b0, f_sel(div)} + 6'd1);
    else
      p = {1'b0, f_deff(div)} + (CNT_W+1)'(1);
    return CNT_W'(p - (CNT_W+1)'(1));
  endfunction

  // Output level for a given counter value and configuration.
  function automatic logic f_level(input logic [CNT_W-1:0] cnt,
                                   input logic [CNT_W-1:0] div,
                                   input logic [1:0]       mode);
    logic [CNT_W:0]   p;
    logic [CNT_W:0]   half;
    logic [CNT_W-1:0] sh;
    p    = {1'b0, f_deff(div)} + (CNT_W+1)'(1);
    half = (p + (CNT_W+1)'(1)) >> 1;
    sh   = cnt >> f_sel(div);
    case (mode)
      2'b10:   return sh[0];
      2'b01:   return (cnt == '0);
      default: return ({1'b0, cnt} < half);
    endcase
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div_a;
  logic [1:0]       r_mode_a;
  logic [CNT_W-1:0] r_div_s;
  logic [1:0]       r_mode_s;
  logic             r_pending;
  logic             r_clk_out;
  logic             r_tick;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_div_a_nxt;
  logic [1:0]       w_mode_a_nxt;
  logic [CNT_W-1:0] w_div_s_nxt;
  logic [1:0]       w_mode_s_nxt;
  logic             w_pending_nxt;
  logic             w_clk_out_nxt;
  logic             w_tick_nxt;
  logic [CNT_W-1:0] w_last;
  logic             w_wrap;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_div_a   <= CNT_W'(1);
      r_mode_a  <= 2'b00;
      r_div_s   <= CNT_W'(1);
      r_mode_s  <= 2'b00;
      r_pending <= 1'b0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_div_a   <= w_div_a_nxt;
      r_mode_a  <= w_mode_a_nxt;
      r_div_s   <= w_div_s_nxt;
      r_mode_s  <= w_mode_s_nxt;
      r_pending <= w_pending_nxt;
      r_clk_out <= w_clk_out_nxt;
      r_tick    <= w_tick_nxt;
    end
  end

  assign w_last = f_last(r_div_a, r_mode_a);
  assign w_wrap = (r_cnt == w_last);

  // Next-state logic
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_div_a_nxt   = r_div_a;
    w_mode_a_nxt  = r_mode_a;
    w_div_s_nxt   = r_div_s;
    w_mode_s_nxt  = r_mode_s;
    w_pending_nxt = r_pending;
    case (r_state)
      S_IDLE: begin
        // An idle load goes straight to both copies: nothing is running.
        if (cfg_load) begin
          w_div_s_nxt   = cfg_div;
          w_mode_s_nxt  = cfg_mode;
          w_div_a_nxt   = cfg_div;
          w_mode_a_nxt  = cfg_mode;
          w_pending_nxt = 1'b0;
        end
        if (en) begin
          w_state_nxt   = S_RUN;
          w_cnt_nxt     = '0;
          w_pending_nxt = 1'b0;
          if (!cfg_load) begin
            w_div_a_nxt  = r_div_s;
            w_mode_a_nxt = r_mode_s;
          end
        end
      end
      default: begin
        if (!en) begin
          // Abort mid-period; a load here is kept for the next enable.
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          if (cfg_load) begin
            w_div_s_nxt   = cfg_div;
            w_mode_s_nxt  = cfg_mode;
            w_pending_nxt = 1'b1;
          end
        end else if (w_wrap) begin
          // Shadow equals active whenever nothing is pending, so copying
          // unconditionally is safe and keeps the boundary logic simple.
          w_cnt_nxt     = '0;
          w_pending_nxt = 1'b0;
          if (cfg_load) begin
            w_div_s_nxt  = cfg_div;
            w_mode_s_nxt = cfg_mode;
            w_div_a_nxt  = cfg_div;
            w_mode_a_nxt = cfg_mode;
          end else begin
            w_div_a_nxt  = r_div_s;
            w_mode_a_nxt = r_mode_s;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (cfg_load) begin
            w_div_s_nxt   = cfg_div;
            w_mode_s_nxt  = cfg_mode;
            w_pending_nxt = 1'b1;
          end
        end
      end
    endcase
  end

  // Output logic: registered outputs are derived from the next counter and
  // next active config so that clk_out always matches the current count.
  always_comb begin
    w_clk_out_nxt = 1'b0;
    w_tick_nxt    = 1'b0;
    if (w_state_nxt == S_RUN)
      w_clk_out_nxt = f_level(w_cnt_nxt, w_div_a_nxt, w_mode_a_nxt);
    if ((r_state == S_RUN) && en && w_wrap)
      w_tick_nxt = 1'b1;
  end

  assign clk_out     = r_clk_out;
  assign tick        = r_tick;
  assign cfg_pending = r_pending;
  assign dbg_state   = r_state;
  assign dbg_cnt     = r_cnt;

endmodule

// File: tb/tb_prog_clock_divider.sv
module tb_prog_clock_divider;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [CNT_W-1:0] cfg_div;
  logic [1:0]       cfg_mode;
  logic             cfg_load;
  logic             clk_out;
  logic             tick;
  logic             cfg_pending;
  logic             dbg_state;
  logic [CNT_W-1:0] dbg_cnt;

  int n_vec;
  int n_err;

  prog_clock_divider #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .cfg_div     (cfg_div),
    .cfg_mode    (cfg_mode),
    .cfg_load    (cfg_load),
    .clk_out     (clk_out),
    .tick        (tick),
    .cfg_pending (cfg_pending),
    .dbg_state   (dbg_state),
    .dbg_cnt     (dbg_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit      m_valid;
  bit      m_run;
  longint  m_cnt;
  longint  m_div_a, m_div_s;
  int      m_mode_a, m_mode_s;
  bit      m_pend;
  bit      m_tick;

  function automatic longint sel_of(longint div);
    longint s;
    s = div % 32;
    return (s > CNT_W - 1) ? CNT_W - 1 : s;
  endfunction

  function automatic longint period_of(longint div, int mode);
    if (mode == 2) return longint'(1) << (sel_of(div) + 1);
    return ((div == 0) ? 1 : div) + 1;
  endfunction

  function automatic bit level_of(longint cnt, longint div, int mode);
    longint p;
    if (mode == 2) return ((cnt >> sel_of(div)) & 1) != 0;
    if (mode == 1) return cnt == 0;
    p = period_of(div, mode);
    return cnt < (p + 1) / 2;
  endfunction

  always @(posedge clk) begin
    m_tick = 0;
    if (!rst_n) begin
      m_valid = 1; m_run = 0; m_cnt = 0; m_pend = 0;
      m_div_a = 1; m_div_s = 1; m_mode_a = 0; m_mode_s = 0;
    end else if (!m_run) begin
      if (cfg_load) begin
        m_div_a = cfg_div; m_mode_a = cfg_mode;
        m_div_s = cfg_div; m_mode_s = cfg_mode;
        m_pend  = 0;
      end
      if (en) begin
        if (m_pend) begin m_div_a = m_div_s; m_mode_a = m_mode_s; end
        m_pend = 0; m_run = 1; m_cnt = 0;
      end
    end else if (!en) begin
      if (cfg_load) begin m_div_s = cfg_div; m_mode_s = cfg_mode; m_pend = 1; end
      m_run = 0; m_cnt = 0;
    end else if (m_cnt == period_of(m_div_a, m_mode_a) - 1) begin
      m_cnt = 0; m_tick = 1;
      if (cfg_load) begin
        m_div_s = cfg_div; m_mode_s = cfg_mode;
        m_div_a = cfg_div; m_mode_a = cfg_mode;
      end else if (m_pend) begin
        m_div_a = m_div_s; m_mode_a = m_mode_s;
      end
      m_pend = 0;
    end else begin
      m_cnt = m_cnt + 1;
      if (cfg_load) begin m_div_s = cfg_div; m_mode_s = cfg_mode; m_pend = 1; end
    end
  end

  // ---------------- scoreboard / compare ----------------
  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("clk_out",     clk_out,     m_run ? level_of(m_cnt, m_div_a, m_mode_a) : 0);
      chk("tick",        tick,        m_tick);
      chk("cfg_pending", cfg_pending, m_pend);
      chk("state",       dbg_state,   m_run);
      chk("cnt",         dbg_cnt,     m_cnt);
    end
  end

  // ---------------- driver tasks ----------------
  logic [63:0] c_clk, c_tick, c_pend;

  task automatic cap(input int n);
    c_clk = '0; c_tick = '0; c_pend = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      c_clk[n-1-i]  = clk_out;
      c_tick[n-1-i] = tick;
      c_pend[n-1-i] = cfg_pending;
    end
  endtask

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [CNT_W-1:0] d, input logic [1:0] m);
    cfg_load = 1; cfg_div = d; cfg_mode = m;
  endtask

  // Return to idle, load a config while idle, then enable.
  task automatic idle_load_run(input logic [CNT_W-1:0] d, input logic [1:0] m);
    en = 0; cfg_load = 0;
    cap(1);
    do_load(d, m);
    cap(1);
    cfg_load = 0; en = 1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 0; en = 0; cfg_load = 0; cfg_div = '0; cfg_mode = 2'b00;
    cap(2);
    lit("reset_clk_out", 64'(clk_out), 64'd0);
    lit("reset_tick",    64'(tick), 64'd0);
    lit("reset_pending", 64'(cfg_pending), 64'd0);

    // default config straight out of reset: divide by 2
    rst_n = 1; en = 1;
    cap(8);
    lit("default_clk",  c_clk,  64'b10101010);
    lit("default_tick", c_tick, 64'b00101010);

    // square P=5
    idle_load_run(16'd4, 2'b00);
    cap(10);
    lit("sq5_clk",  c_clk,  64'b1110011100);
    lit("sq5_tick", c_tick, 64'b0000010000);
    lit("sq5_pend", c_pend, 64'b0);

    // pulse P=3
    idle_load_run(16'd2, 2'b01);
    cap(6);
    lit("pulse3_clk",  c_clk,  64'b100100);
    lit("pulse3_tick", c_tick, 64'b000100);

    // legacy sel=2, P=8
    idle_load_run(16'd2, 2'b10);
    cap(16);
    lit("leg8_clk",  c_clk,  64'b0000111100001111);
    lit("leg8_tick", c_tick, 64'b0000000010000000);

    // reserved mode acts as square, P=4
    idle_load_run(16'd3, 2'b11);
    cap(8);
    lit("mode11_clk",  c_clk,  64'b11001100);
    lit("mode11_tick", c_tick, 64'b00001000);

    // D=0 behaves as D=1
    idle_load_run(16'd0, 2'b00);
    cap(6);
    lit("d0_clk", c_clk, 64'b101010);

    // run with D=9, load D=1 while cnt=3
    idle_load_run(16'd9, 2'b00);
    cap(4);
    lit("d9_head_clk", c_clk, 64'b1111);
    do_load(16'd1, 2'b00);
    cap(1);
    lit("d9_pend_set", c_pend, 64'b1);
    cfg_load = 0;
    cap(8);
    lit("d9_tail_clk",  c_clk,  64'b00000101);
    lit("d9_tail_pend", c_pend, 64'b11111000);
    lit("d9_tail_tick", c_tick, 64'b00000101);

    // load on the very edge of a wrap: no pending
    cap(1);
    do_load(16'd2, 2'b01);
    cap(1);
    lit("wrap_load_tick", c_tick, 64'b1);
    lit("wrap_load_pend", c_pend, 64'b0);
    cfg_load = 0;
    cap(3);
    lit("wrap_load_clk", c_clk, 64'b001);

    // two loads while pending: the last wins
    do_load(16'd5, 2'b00);
    cap(1);
    do_load(16'd3, 2'b00);
    cap(1);
    cfg_load = 0;
    cap(5);
    lit("last_wins_clk",  c_clk,  64'b11001);
    lit("last_wins_tick", c_tick, 64'b10001);

    // pending config survives an en drop and is applied on enable
    do_load(16'd6, 2'b01);
    cap(1);
    cfg_load = 0; en = 0;
    cap(2);
    lit("drop_pend_idle", c_pend, 64'b11);
    en = 1;
    cap(8);
    lit("drop_pend_clk",  c_clk,  64'b10000001);
    lit("drop_pend_pend", c_pend, 64'b0);

    // en negated mid-period at cnt=2
    cap(2);
    en = 0;
    cap(1);
    lit("en_drop_cnt", 64'(dbg_cnt), 64'd0);
    lit("en_drop_clk", c_clk, 64'b0);
    en = 1;
    cap(1);
    lit("en_resume_clk", c_clk, 64'b1);

    // reset mid-run dominates en and cfg_load
    cap(2);
    rst_n = 0; do_load(16'd7, 2'b01);
    cap(1);
    lit("rst_mid_clk",  c_clk,  64'b0);
    lit("rst_mid_tick", c_tick, 64'b0);
    lit("rst_mid_cnt",  64'(dbg_cnt), 64'd0);
    rst_n = 1; cfg_load = 0;
    cap(6);
    lit("rst_after_clk",  c_clk,  64'b101010);
    lit("rst_after_tick", c_tick, 64'b001010);

    en = 0;
    cap(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
